// File: rtl/packet_rd_responder.sv
// Packet-memory read responder: fetches one or two BRAM words, returns big-endian right-justified data.
// Optional last-word cache enabled by defining LAST_WORD_CACHE_EN.
module packet_rd_responder #(
  parameter int PACKET_BYTE_ADDR_WIDTH = 12,
  parameter int PACKET_ADDR_WIDTH      = PACKET_BYTE_ADDR_WIDTH - 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              rd_en,
  input  logic [PACKET_BYTE_ADDR_WIDTH-1:0] byte_addr,
  input  logic [1:0]                        transfer_sz,
  input  logic [PACKET_BYTE_ADDR_WIDTH:0]   packet_len,
  input  logic                              cache_inv,
  output logic                              mem_ready,
  output logic [31:0]                       packet_data,
  output logic                              oob,
  output logic                              bram_rd_en,
  output logic [PACKET_ADDR_WIDTH-1:0]      bram_addr,
  input  logic [31:0]                       bram_rdata
);

  localparam int BW = PACKET_BYTE_ADDR_WIDTH;
  localparam int AW = PACKET_ADDR_WIDTH;

  typedef enum logic [2:0] {IDLE, ISSUE0, ISSUE1, CAPTURE, DONE} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] w_q, w_d;
  logic [1:0]    off_q, off_d;
  logic [2:0]    size_q, size_d;
  logic          straddle_q, straddle_d;
  logic          hit_q, hit_d;
  logic [31:0]   word0_q, word0_d;
  logic          mem_ready_q, mem_ready_d;
  logic [31:0]   packet_data_q, packet_data_d;
  logic          oob_q, oob_d;
  logic          bram_rd_en_q, bram_rd_en_d;
  logic [AW-1:0] bram_addr_q, bram_addr_d;

  logic [2:0]    req_size;
  logic [AW-1:0] req_w;
  logic [1:0]    req_off;
  logic          req_straddle;
  logic [BW+1:0] req_end;
  logic          req_oob;
  logic          req_hit;
  logic [31:0]   cached_word;

  always_comb begin
    unique case (transfer_sz)
      2'b00:   req_size = 3'd1;
      2'b01:   req_size = 3'd2;
      default: req_size = 3'd4;
    endcase
  end

  assign req_w        = byte_addr[BW-1:2];
  assign req_off      = byte_addr[1:0];
  assign req_straddle = ({1'b0, req_off} + req_size) > 3'd4;
  // Extra headroom bits so a request ending at the top of memory cannot wrap past packet_len.
  assign req_end      = {2'b00, byte_addr} + {{(BW-1){1'b0}}, req_size};
  assign req_oob      = req_end > {1'b0, packet_len};

`ifdef LAST_WORD_CACHE_EN
  logic          cache_valid_q, cache_valid_d;
  logic [AW-1:0] cache_w_q, cache_w_d;
  logic [31:0]   cache_data_q, cache_data_d;

  assign req_hit     = cache_valid_q && !cache_inv && (cache_w_q == req_w);
  assign cached_word = cache_data_q;

  // The entry always describes the last word pulled from BRAM; for a straddle that is word w+1.
  always_comb begin
    cache_valid_d = cache_valid_q;
    cache_w_d     = cache_w_q;
    cache_data_d  = cache_data_q;
    if (state_q == CAPTURE && !hit_q) begin
      cache_valid_d = 1'b1;
      cache_w_d     = straddle_q ? w_q + AW'(1) : w_q;
      cache_data_d  = bram_rdata;
    end
    if (cache_inv) cache_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cache_valid_q <= 1'b0;
      cache_w_q     <= '0;
    end else begin
      cache_valid_q <= cache_valid_d;
      cache_w_q     <= cache_w_d;
    end
  end

  // NOTE: the data word needs no reset; cache_valid_q gates every use of it.
  always_ff @(posedge clk) begin
    cache_data_q <= cache_data_d;
  end
`else
  logic unused_cache_inv;
  assign unused_cache_inv = cache_inv;
  assign req_hit          = 1'b0;
  assign cached_word      = '0;
`endif

  // Assembly: select bytes off..off+size-1 of {word0, word1}, MSB first, then right-justify.
  logic [31:0] last_word;
  logic [63:0] cat;
  logic [5:0]  shamt;
  logic [63:0] shifted;
  logic [31:0] size_mask;
  logic [31:0] assembled;

  always_comb begin
    last_word = hit_q ? cached_word : bram_rdata;
    cat       = straddle_q ? {word0_q, last_word} : {last_word, 32'h0};
    shamt     = 6'd0 - ({1'b0, off_q, 3'b000} + {size_q, 3'b000});
    shifted   = cat >> shamt;
    unique case (size_q)
      3'd1:    size_mask = 32'h0000_00ff;
      3'd2:    size_mask = 32'h0000_ffff;
      default: size_mask = 32'hffff_ffff;
    endcase
    assembled = shifted[31:0] & size_mask;
  end

  // Outputs are registered and set from the next state, so they line up with the state they belong to.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d       = state_q;
    w_d           = w_q;
    off_d         = off_q;
    size_d        = size_q;
    straddle_d    = straddle_q;
    hit_d         = hit_q;
    word0_d       = word0_q;
    mem_ready_d   = 1'b0;
    packet_data_d = packet_data_q;
    oob_d         = oob_q;
    bram_rd_en_d  = 1'b0;
    bram_addr_d   = bram_addr_q;

    unique case (state_q)
      IDLE: begin
        if (rd_en) begin
          w_d        = req_w;
          off_d      = req_off;
          size_d     = req_size;
          straddle_d = req_straddle;
          hit_d      = req_hit && !req_straddle && !req_oob;
          if (req_oob) begin
            state_d       = DONE;
            packet_data_d = '0;
            oob_d         = 1'b1;
            mem_ready_d   = 1'b1;
          end else if (req_hit && !req_straddle) begin
            state_d = CAPTURE;
          end else begin
            state_d      = ISSUE0;
            bram_rd_en_d = 1'b1;
            bram_addr_d  = req_w;
          end
        end
      end
      ISSUE0: begin
        if (straddle_q) begin
          state_d      = ISSUE1;
          bram_rd_en_d = 1'b1;
          bram_addr_d  = w_q + AW'(1);
        end else begin
          state_d = CAPTURE;
        end
      end
      ISSUE1: begin
        word0_d = bram_rdata;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        packet_data_d = assembled;
        oob_d         = 1'b0;
        mem_ready_d   = 1'b1;
        state_d       = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      w_q           <= '0;
      off_q         <= '0;
      size_q        <= 3'd1;
      straddle_q    <= 1'b0;
      hit_q         <= 1'b0;
      word0_q       <= '0;
      mem_ready_q   <= 1'b0;
      packet_data_q <= '0;
      oob_q         <= 1'b0;
      bram_rd_en_q  <= 1'b0;
      bram_addr_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
      state_q       <= state_d;
      w_q           <= w_d;
      off_q         <= off_d;
      size_q        <= size_d;
      straddle_q    <= straddle_d;
      hit_q         <= hit_d;
      word0_q       <= word0_d;
      mem_ready_q   <= mem_ready_d;
      packet_data_q <= packet_data_d;
      oob_q         <= oob_d;
      bram_rd_en_q  <= bram_rd_en_d;
      bram_addr_q   <= bram_addr_d;
    end
  end

  assign mem_ready   = mem_ready_q;
  assign packet_data = packet_data_q;
  assign oob         = oob_q;
  assign bram_rd_en  = bram_rd_en_q;
  assign bram_addr   = bram_addr_q;

endmodule

// File: tb/tb_packet_rd_responder.sv
// Bench for packet_rd_responder: directed and random reads against a byte-level reference model.
// Cache-hit scenarios are compiled in when LAST_WORD_CACHE_EN is defined.
module tb_packet_rd_responder;

  localparam int BW = 12;
  localparam int AW = 10;
`ifdef LAST_WORD_CACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rd_en = 1'b0;
  logic          cache_inv = 1'b0;
  logic [BW-1:0] byte_addr = '0;
  logic [1:0]    transfer_sz = '0;
  logic [BW:0]   packet_len = '0;
  logic          mem_ready, oob, bram_rd_en;
  logic [31:0]   packet_data;
  logic [31:0]   bram_rdata = '0;
  logic [AW-1:0] bram_addr;

  logic [31:0] tb_mem [1024];
  int n_pass  = 0;
  int n_total = 0;

  // Reference cache state: index of the last word the design should have read from BRAM.
  bit m_valid = 1'b0;
  int m_idx   = 0;

  packet_rd_responder #(.PACKET_BYTE_ADDR_WIDTH(BW)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .byte_addr(byte_addr),
    .transfer_sz(transfer_sz), .packet_len(packet_len), .cache_inv(cache_inv),
    .mem_ready(mem_ready), .packet_data(packet_data), .oob(oob),
    .bram_rd_en(bram_rd_en), .bram_addr(bram_addr), .bram_rdata(bram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bram_rd_en) bram_rdata <= tb_mem[bram_addr];

  // Expected result from the byte-level view of packet memory.
  task automatic predict(input int a, input int sz, input int len,
                         output logic [31:0] d, output logic o, output int lat, output int nrd);
    int size;
    bit strad, hit;
    size = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    d = '0;
    o = 1'b0;
    if (a + size > len) begin
      o = 1'b1; lat = 1; nrd = 0;
    end else begin
      for (int i = 0; i < size; i++)
        d = {d[23:0], tb_mem[(a + i) / 4][31 - 8 * ((a + i) % 4) -: 8]};
      strad = ((a % 4) + size) > 4;
      hit   = CACHE_ON && m_valid && !strad && ((a / 4) == m_idx);
      lat   = hit ? 2 : (strad ? 4 : 3);
      nrd   = hit ? 0 : (strad ? 2 : 1);
      if (!hit) begin
        m_valid = CACHE_ON;
        m_idx   = (a + size - 1) / 4;
      end
    end
  endtask

  // Issues one request in cycle T and watches 8 following cycles; inputs are scrambled after acceptance.
  task automatic run_req(input int a, input int sz, input int len,
                         output int lat, output logic [31:0] data, output logic o,
                         output int nrd, output logic [AW-1:0] a0, output logic [AW-1:0] a1,
                         output int pulses);
    @(negedge clk);
    rd_en = 1'b1; byte_addr = BW'(a); transfer_sz = 2'(sz); packet_len = (BW+1)'(len);
    lat = -1; data = '0; o = 1'b0; nrd = 0; a0 = '0; a1 = '0; pulses = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        rd_en = 1'b0;
        byte_addr = BW'($urandom);
        transfer_sz = 2'($urandom);
        packet_len = (BW+1)'($urandom);
      end
      if (bram_rd_en) begin
        if (nrd == 0) a0 = bram_addr; else a1 = bram_addr;
        nrd++;
      end
      if (mem_ready) begin
        pulses++;
        if (lat < 0) begin lat = k; data = packet_data; o = oob; end
      end
    end
  endtask

  task automatic pulse_inv();
    @(negedge clk); cache_inv = 1'b1;
    @(negedge clk); cache_inv = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_total++; if (mem_ready !== 1'b0) $display("FAIL reset_mem_ready: got %b want 0", mem_ready); else n_pass++;
    n_total++; if (packet_data !== 32'h0) $display("FAIL reset_packet_data: got %h want 0", packet_data); else n_pass++;
    n_total++; if (oob !== 1'b0) $display("FAIL reset_oob: got %b want 0", oob); else n_pass++;
    n_total++; if (bram_rd_en !== 1'b0) $display("FAIL reset_bram_rd_en: got %b want 0", bram_rd_en); else n_pass++;
    n_total++; if (bram_addr !== '0) $display("FAIL reset_bram_addr: got %h want 0", bram_addr); else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_directed();
    int          ta [6] = '{1, 3, 2, 4, 5, 7};
    int          ts [6] = '{0, 1, 2, 2, 2, 0};
    logic [31:0] td [6] = '{32'h22, 32'h4455, 32'h33445566, 32'h55667788, 32'h0, 32'h88};
    logic [31:0] ed, gd;
    logic        eo, go;
    int          el, en, gl, gn, gp;
    logic [AW-1:0] g0, g1;
    for (int i = 0; i < 6; i++) begin
      pulse_inv();
      predict(ta[i], ts[i], 8, ed, eo, el, en);
      run_req(ta[i], ts[i], 8, gl, gd, go, gn, g0, g1, gp);
      n_total++; if (gd !== td[i]) $display("FAIL dir_data[%0d]: got %h want %h", i, gd, td[i]); else n_pass++;
      n_total++; if (go !== eo) $display("FAIL dir_oob[%0d]: got %b want %b", i, go, eo); else n_pass++;
      n_total++; if (gl != el) $display("FAIL dir_latency[%0d]: got %0d want %0d", i, gl, el); else n_pass++;
      n_total++; if (gn != en) $display("FAIL dir_bram_reads[%0d]: got %0d want %0d", i, gn, en); else n_pass++;
      n_total++; if (gp != 1) $display("FAIL dir_ready_pulses[%0d]: got %0d want 1", i, gp); else n_pass++;
      if (en >= 1) begin
        n_total++; if (g0 !== AW'(ta[i] / 4)) $display("FAIL dir_addr0[%0d]: got %h want %h", i, g0, ta[i] / 4); else n_pass++;
      end
      if (en == 2) begin
        n_total++; if (g1 !== AW'(ta[i] / 4 + 1)) $display("FAIL dir_addr1[%0d]: got %h want %h", i, g1, ta[i] / 4 + 1); else n_pass++;
      end
    end
  endtask

  task automatic test_hold();
    logic [31:0] gd;
    logic        go;
    int          gl, gn, gp;
    logic [AW-1:0] g0, g1;
    run_req(5, 2, 8, gl, gd, go, gn, g0, g1, gp);
    repeat (3) @(negedge clk);
    n_total++; if (oob !== 1'b1) $display("FAIL hold_oob_flag: got %b want 1", oob); else n_pass++;
    pulse_inv();
    run_req(7, 0, 8, gl, gd, go, gn, g0, g1, gp);
    m_valid = CACHE_ON; m_idx = 1;
    repeat (3) @(negedge clk);
    n_total++; if (packet_data !== 32'h88) $display("FAIL hold_data: got %h want 00000088", packet_data); else n_pass++;
    n_total++; if (oob !== 1'b0) $display("FAIL hold_oob_clear: got %b want 0", oob); else n_pass++;
  endtask

  task automatic test_busy();
    int pulses = 0;
    logic [31:0] first_data = '0;
    pulse_inv();
    @(negedge clk);
    rd_en = 1'b1; byte_addr = 12'd1; transfer_sz = 2'b00; packet_len = 13'd8;
    @(negedge clk);
    byte_addr = 12'd4; transfer_sz = 2'b10;
    for (int k = 2; k <= 10; k++) begin
      @(negedge clk);
      rd_en = 1'b0;
      if (mem_ready) begin
        if (pulses == 0) first_data = packet_data;
        pulses++;
      end
    end
    m_valid = CACHE_ON; m_idx = 0;
    n_total++; if (pulses != 1) $display("FAIL busy_pulses: got %0d want 1", pulses); else n_pass++;
    n_total++; if (first_data !== 32'h22) $display("FAIL busy_data: got %h want 00000022", first_data); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    logic [31:0] ed, gd;
    logic        eo, go;
    int          el, en, gl, gn, gp;
    logic [AW-1:0] g0, g1;
    pulse_inv();
    @(negedge clk);
    rd_en = 1'b1; byte_addr = 12'd3; transfer_sz = 2'b01; packet_len = 13'd8;
    @(negedge clk);
    rd_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_valid = 1'b0;
    #1;
    n_total++; if (bram_rd_en !== 1'b0) $display("FAIL midrst_bram_rd_en: got %b want 0", bram_rd_en); else n_pass++;
    n_total++; if (bram_addr !== '0) $display("FAIL midrst_bram_addr: got %h want 0", bram_addr); else n_pass++;
    n_total++; if (packet_data !== 32'h0) $display("FAIL midrst_packet_data: got %h want 0", packet_data); else n_pass++;
    n_total++; if ({mem_ready, oob} !== 2'b00) $display("FAIL midrst_ready_oob: got %b want 00", {mem_ready, oob}); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (mem_ready) pulses++;
    end
    n_total++; if (pulses != 0) $display("FAIL midrst_stray_ready: got %0d want 0", pulses); else n_pass++;
    predict(3, 1, 8, ed, eo, el, en);
    run_req(3, 1, 8, gl, gd, go, gn, g0, g1, gp);
    n_total++; if (gd !== ed) $display("FAIL midrst_next_data: got %h want %h", gd, ed); else n_pass++;
    n_total++; if (gl != el) $display("FAIL midrst_next_latency: got %0d want %0d", gl, el); else n_pass++;
  endtask

  task automatic test_cache_inv();
    logic [31:0] ed, gd;
    logic        eo, go;
    int          el, en, gl, gn, gp;
    logic [AW-1:0] g0, g1;
    pulse_inv();
    predict(4, 0, 8, ed, eo, el, en);
    run_req(4, 0, 8, gl, gd, go, gn, g0, g1, gp);
    pulse_inv();
    predict(6, 0, 8, ed, eo, el, en);
    run_req(6, 0, 8, gl, gd, go, gn, g0, g1, gp);
    n_total++; if (gd !== 32'h77) $display("FAIL inv_data: got %h want 00000077", gd); else n_pass++;
    n_total++; if (gl != 3) $display("FAIL inv_latency: got %0d want 3", gl); else n_pass++;
    n_total++; if (gn != 1) $display("FAIL inv_bram_reads: got %0d want 1", gn); else n_pass++;
  endtask

`ifdef LAST_WORD_CACHE_EN
  task automatic test_cache_hit();
    logic [31:0] ed, gd;
    logic        eo, go;
    int          el, en, gl, gn, gp;
    logic [AW-1:0] g0, g1;
    pulse_inv();
    predict(4, 0, 8, ed, eo, el, en);
    run_req(4, 0, 8, gl, gd, go, gn, g0, g1, gp);
    n_total++; if (gd !== 32'h55) $display("FAIL hit_first_data: got %h want 00000055", gd); else n_pass++;
    predict(6, 0, 8, ed, eo, el, en);
    run_req(6, 0, 8, gl, gd, go, gn, g0, g1, gp);
    n_total++; if (gd !== 32'h77) $display("FAIL hit_data: got %h want 00000077", gd); else n_pass++;
    n_total++; if (gl != 2) $display("FAIL hit_latency: got %0d want 2", gl); else n_pass++;
    n_total++; if (gn != 0) $display("FAIL hit_bram_reads: got %0d want 0", gn); else n_pass++;
  endtask
`endif

  task automatic test_random();
    logic [31:0] ed, gd;
    logic        eo, go;
    int          el, en, gl, gn, gp, a, sz, len;
    logic [AW-1:0] g0, g1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 5) == 0) pulse_inv();
      sz = int'($urandom_range(0, 3));
      if (i % 2 == 0) begin
        a   = int'($urandom_range(0, 31));
        len = int'($urandom_range(20, 40));
      end else begin
        a   = int'($urandom_range(0, 4095));
        len = int'($urandom_range(0, 4096));
      end
      predict(a, sz, len, ed, eo, el, en);
      run_req(a, sz, len, gl, gd, go, gn, g0, g1, gp);
      n_total++; if (gd !== ed) $display("FAIL rnd_data[%0d] a=%0d sz=%0d len=%0d: got %h want %h", i, a, sz, len, gd, ed); else n_pass++;
      n_total++; if (go !== eo) $display("FAIL rnd_oob[%0d]: got %b want %b", i, go, eo); else n_pass++;
      n_total++; if (gl != el) $display("FAIL rnd_latency[%0d]: got %0d want %0d", i, gl, el); else n_pass++;
      n_total++; if (gn != en) $display("FAIL rnd_bram_reads[%0d]: got %0d want %0d", i, gn, en); else n_pass++;
      n_total++; if (gp != 1) $display("FAIL rnd_ready_pulses[%0d]: got %0d want 1", i, gp); else n_pass++;
      if (en >= 1) begin
        n_total++; if (g0 !== AW'(a / 4)) $display("FAIL rnd_addr0[%0d]: got %h want %h", i, g0, a / 4); else n_pass++;
      end
    end
  endtask

  initial begin
    tb_mem[0] = 32'h11223344;
    tb_mem[1] = 32'h55667788;
    for (int i = 2; i < 1024; i++) tb_mem[i] = $urandom;
    test_reset();
    test_directed();
    test_hold();
    test_busy();
    test_reset_mid();
    test_cache_inv();
`ifdef LAST_WORD_CACHE_EN
    test_cache_hit();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
